// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer
//   Produces the 2-bit pattern select for the VGA pattern generator from two board push buttons.
//   key_n[0] requests a step to the next mode. key_n[1] toggles between manual and auto-cycle
//   operation. A mode change only takes effect on a frame boundary (synchronized vsync falling
//   edge), so a frame never shows two modes.
//
//   Build option: define VGA_SEQ_DEBOUNCE_EN to debounce the keys over DEBOUNCE_CYCLES stable
//   clocks. With it undefined, the synchronized key level is used directly, and DEBOUNCE_CYCLES
//   and DB_W have no effect.
//
// Ports
//   clk         system clock (the pixel clock is derived from it)
//   rst_n       asynchronous reset, active low
//   key_n[1:0]  board buttons, active low, asynchronous; [0]=next mode, [1]=auto toggle
//   vsync       vsync from the VGA timing generator, active low
//   mode[1:0]   pattern select to the generator
//   auto_on     high while auto-cycling
//   frame_tick  one-cycle pulse per frame boundary, aligned with any new mode value

module vga_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 19,
  parameter int unsigned FRAMES_PER_STEP = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_n,
  input  logic       vsync,
  output logic [1:0] mode,
  output logic       auto_on,
  output logic       frame_tick
);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 1 ||
      (longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << DB_W) ||
      FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 255) begin : g_param_err
    $error("vga_mode_sequencer: illegal DEBOUNCE_CYCLES/DB_W/FRAMES_PER_STEP");
  end

  typedef enum logic [0:0] {StManual, StAuto} state_e;

  localparam logic [7:0] FrameLast = 8'(FRAMES_PER_STEP - 1);

  // Synchronizers; preset to the released / inactive level.
  logic [1:0] key_s1_q, key_s2_q;
  logic       vs_s1_q, vs_s2_q, vs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q  <= 2'b11;
      key_s2_q  <= 2'b11;
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      key_s1_q  <= key_n;
      key_s2_q  <= key_s1_q;
      vs_s1_q   <= vsync;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
    end
  end

  logic fb;
  assign fb = vs_prev_q & ~vs_s2_q;

  // Accepted (stable) key level per button.
  logic [1:0] stable;

`ifdef VGA_SEQ_DEBOUNCE_EN
  localparam logic [DB_W-1:0] DbLast = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            stable_q, stable_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  // The counter only runs while the synced level disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (key_s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = key_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 2'b11;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = key_s2_q;
`endif

  // Press event: accepted level went 1 -> 0. Releases are ignored.
  logic [1:0] stable_prev_q, press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev_q <= 2'b11;
      press_q       <= 2'b00;
    end else begin
      stable_prev_q <= stable;
      press_q       <= stable_prev_q & ~stable;
    end
  end

  logic next_ev, toggle_ev;
  assign next_ev   = press_q[0];
  assign toggle_ev = press_q[1];

  // Sequencer state.
  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       pending_q, pending_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       frame_tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StManual;
      mode_q       <= 2'd0;
      pending_q    <= 1'b0;
      frame_cnt_q  <= 8'd0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_tick_q <= fb;
    end
  end

  // A toggle press takes priority over everything else in its cycle, including a next press.
  // A next press arriving with fb is applied after that fb's decision, so it waits for the
  // following boundary.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    if (toggle_ev) begin
      pending_d = 1'b0;
      if (state_q == StManual) begin
        state_d     = StAuto;
        frame_cnt_d = 8'd0;
      end else begin
        state_d = StManual;
      end
    end else begin
      unique case (state_q)
        StManual: begin
          if (fb && pending_q) begin
            mode_d    = mode_q + 2'd1;
            pending_d = 1'b0;
          end
        end
        StAuto: begin
          if (fb) begin
            if (frame_cnt_q == FrameLast || pending_q) begin
              mode_d      = mode_q + 2'd1;
              frame_cnt_d = 8'd0;
              pending_d   = 1'b0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
      endcase
      if (next_ev) begin
        pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    mode       = mode_q;
    auto_on    = (state_q == StAuto);
    frame_tick = frame_tick_q;
  end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer. Stimulus pushes the expected mode/auto_on of
// each frame boundary into a queue; a monitor pops and compares on every frame_tick and checks
// that mode holds between ticks.

module tb_vga_mode_sequencer;

  localparam int D = 4;
  localparam int F = 3;
`ifdef VGA_SEQ_DEBOUNCE_EN
  localparam int THR = D;  // shortest accepted press, in clk cycles
  localparam int DM  = D;  // extra press latency from debouncing
`else
  localparam int THR = 1;
  localparam int DM  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_n;
  logic       vsync;
  logic [1:0] mode;
  logic       auto_on;
  logic       frame_tick;

  vga_mode_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .DB_W           (4),
    .FRAMES_PER_STEP(F)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .vsync     (vsync),
    .mode      (mode),
    .auto_on   (auto_on),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] mode;
    logic       auto_on;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] exp_mode_cur = 2'd0;

  // Reference model state.
  int m_mode    = 0;
  bit m_auto    = 0;
  bit m_pending = 0;
  int m_cnt     = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode    = 0;
    m_auto    = 0;
    m_pending = 0;
    m_cnt     = 0;
  endfunction

  function automatic void model_fb();
    bit   do_step;
    exp_t e;
    do_step = m_auto ? (m_cnt == F - 1 || m_pending) : m_pending;
    if (do_step) begin
      m_mode    = (m_mode + 1) % 4;
      m_pending = 0;
      if (m_auto) m_cnt = 0;
    end else if (m_auto) begin
      m_cnt++;
    end
    e.mode    = 2'(m_mode);
    e.auto_on = m_auto;
    exp_q.push_back(e);
  endfunction

  function automatic void model_press(input bit nx, input bit au);
    if (au) begin
      m_auto    = !m_auto;
      m_pending = 0;
      if (m_auto) m_cnt = 0;
    end else if (nx) begin
      m_pending = 1;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    vsync = 1'b0;
    model_fb();
    step($urandom_range(1, 4));
    vsync = 1'b1;
    step($urandom_range(4, 12));
  endtask

  task automatic do_press(input logic [1:0] mask, input int len);
    key_n = ~mask;
    step(len);
    key_n = 2'b11;
    if (len >= THR) model_press(mask[0], mask[1]);
    step(D + 8);
    check("auto_on_after_press", {1'b0, auto_on}, {1'b0, m_auto});
  endtask

  // Next press whose event lands in the same cycle as a frame boundary.
  task automatic press_at_fb();
    key_n[0] = 1'b0;
    step(DM + 1);
    vsync = 1'b0;
    model_fb();
    model_press(1'b1, 1'b0);
    step(3);
    vsync = 1'b1;
    step(D + 2);
    key_n[0] = 1'b1;
    step(D + 8);
  endtask

  // Reset in the middle of a key debounce; outputs must clear without a clock edge.
  task automatic do_reset();
    key_n[0] = 1'b0;
    step(2);
    rst_n = 1'b0;
    #2;
    check("reset_mode", mode, 2'd0);
    check("reset_auto_on", {1'b0, auto_on}, 2'd0);
    check("reset_frame_tick", {1'b0, frame_tick}, 2'd0);
    model_reset();
    exp_q.delete();
    exp_mode_cur = 2'd0;
    step(2);
    key_n[0] = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(D + 8);
    check("auto_on_after_reset", {1'b0, auto_on}, 2'd0);
  endtask

  // Monitor: every frame_tick consumes one expected entry; mode must hold otherwise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      if (frame_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_tick at %0t: got pulse, expected none (mode=%0d)",
                   $time, mode);
        end else begin
          e = exp_q.pop_front();
          exp_mode_cur = e.mode;
          check("tick_mode", mode, e.mode);
          check("tick_auto_on", {1'b0, auto_on}, {1'b0, e.auto_on});
        end
      end else begin
        check("mode_hold", mode, exp_mode_cur);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    rst_n = 1'b0;
    key_n = 2'b11;
    vsync = 1'b1;
    step(3);
    check("init_mode", mode, 2'd0);
    check("init_auto_on", {1'b0, auto_on}, 2'd0);
    check("init_frame_tick", {1'b0, frame_tick}, 2'd0);
    rst_n = 1'b1;
    step(2);

    // Idle with keys released: ticks only, no steps.
    repeat (8) do_frame();

    // Single next presses: 0 -> 1 -> 2 -> 3 -> 0.
    repeat (4) begin
      do_press(2'b01, 20);
      do_frame();
    end

    // Several presses before one boundary give a single step.
    repeat (3) do_press(2'b01, D + 2);
    do_frame();
    do_frame();

    // Auto mode: steps every F frames, then back to manual.
    do_press(2'b10, D + 3);
    repeat (9) do_frame();
    do_press(2'b10, D + 3);
    repeat (3) do_frame();

    // Short glitch (accepted only without debouncing).
    do_press(2'b01, 3);
    do_frame();
    do_frame();

    // Both keys together: toggle wins, no pending step.
    do_press(2'b11, D + 2);
    do_frame();
    do_frame();

    // Press coinciding with a boundary, in auto and in manual.
    press_at_fb();
    do_frame();
    do_press(2'b10, D + 2);
    press_at_fb();
    do_frame();

    // Reset mid-count in auto.
    do_press(2'b10, D + 2);
    do_frame();
    do_reset();
    repeat (2) do_frame();

    // Randomized operation mix.
    repeat (150) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      do_frame();
      else if (r <= 6) do_press(2'b01, $urandom_range(1, D + 6));
      else if (r == 7) do_press(2'b10, $urandom_range(1, D + 6));
      else if (r == 8) do_press(2'b11, $urandom_range(1, D + 6));
      else             press_at_fb();
    end

    step(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frame_ticks: got %0d unconsumed, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
